// File: rtl/psum_requant.sv
// Two-stage multi-lane requantiser: round + arithmetic shift, then ReLU/saturate,
// with a saturating count of clipped lanes. Valid/ready on both sides.

module psum_requant_lane #(
  parameter int I_SUM_BW = 21,
  parameter int O_SUM_BW = 16,
  parameter int SHIFT_BW = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                ld1_i,
  input  logic                adv_i,
  input  logic [SHIFT_BW-1:0] shift_i,
  input  logic                relu_i,
  input  logic [I_SUM_BW-1:0] x_i,
  output logic [O_SUM_BW-1:0] y_o,
  output logic                clip_o
);
  localparam logic signed [I_SUM_BW:0] MAXV =
    {{(I_SUM_BW+2-O_SUM_BW){1'b0}}, {(O_SUM_BW-1){1'b1}}};
  localparam logic signed [I_SUM_BW:0] MINV =
    {{(I_SUM_BW+2-O_SUM_BW){1'b1}}, {(O_SUM_BW-1){1'b0}}};

  logic signed [I_SUM_BW:0] xe, rnd, r_d, r_q;
  logic        [O_SUM_BW-1:0] y_d, y_q;

  // One guard bit keeps x + 2^(sh-1) from overflowing.
  always_comb begin
    xe  = {x_i[I_SUM_BW-1], x_i};
    rnd = '0;
    r_d = xe;
    if (shift_i != '0) begin
      rnd = (I_SUM_BW+1)'(1) << (shift_i - 1'b1);
      r_d = (xe + rnd) >>> shift_i;
    end
  end

  always_comb begin
    y_d    = r_q[O_SUM_BW-1:0];
    clip_o = 1'b0;
    if (relu_i && r_q < 0) begin
      y_d = '0;
    end else if (r_q > MAXV) begin
      y_d    = MAXV[O_SUM_BW-1:0];
      clip_o = 1'b1;
    end else if (r_q < MINV) begin
      y_d    = MINV[O_SUM_BW-1:0];
      clip_o = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q <= '0;
      y_q <= '0;
    end else begin
      if (ld1_i) r_q <= r_d;
      if (adv_i) y_q <= y_d;
    end
  end

  assign y_o = y_q;
endmodule

module psum_requant #(
  parameter int LANES    = 4,
  parameter int I_SUM_BW = 21,
  parameter int O_SUM_BW = 16,
  parameter int SHIFT_BW = 4,
  parameter int CNT_BW   = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [SHIFT_BW-1:0]       i_shift,
  input  logic                      i_relu_en,
  input  logic                      i_clr_cnt,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [LANES*I_SUM_BW-1:0] s_psum,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [LANES*O_SUM_BW-1:0] m_psum,
  output logic [CNT_BW-1:0]         o_sat_cnt
);
  localparam int CW = $clog2(LANES+1);
  localparam logic [CNT_BW:0] CNT_MAX = {1'b0, {CNT_BW{1'b1}}};

  logic              adv, ld1;
  logic              v1_q, m_valid_q, relu1_q;
  logic [LANES-1:0]  clip;
  logic [CW-1:0]     nclip;
  logic [CNT_BW:0]   sum;
  logic [CNT_BW-1:0] cnt_d, cnt_q;

  assign adv     = !m_valid_q || m_ready;
  assign ld1     = s_valid && adv;
  assign s_ready = adv;

  genvar k;
  generate
    for (k = 0; k < LANES; k++) begin : g_lane
      psum_requant_lane #(
        .I_SUM_BW(I_SUM_BW), .O_SUM_BW(O_SUM_BW), .SHIFT_BW(SHIFT_BW)
      ) u_lane (
        .clk     (clk),
        .reset_n (reset_n),
        .ld1_i   (ld1),
        .adv_i   (adv),
        .shift_i (i_shift),
        .relu_i  (relu1_q),
        .x_i     (s_psum[k*I_SUM_BW +: I_SUM_BW]),
        .y_o     (m_psum[k*O_SUM_BW +: O_SUM_BW]),
        .clip_o  (clip[k])
      );
    end
  endgenerate

  // Clear wins over the increment from the beat loading stage 2 this cycle.
  always_comb begin
    nclip = '0;
    for (int i = 0; i < LANES; i++) nclip = nclip + CW'(clip[i]);
    sum   = {1'b0, cnt_q} + (CNT_BW+1)'(nclip);
    cnt_d = cnt_q;
    if (i_clr_cnt)        cnt_d = '0;
    else if (adv && v1_q) cnt_d = (sum > CNT_MAX) ? CNT_MAX[CNT_BW-1:0] : sum[CNT_BW-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1_q      <= 1'b0;
      relu1_q   <= 1'b0;
      m_valid_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (adv) begin
        v1_q      <= s_valid;
        m_valid_q <= v1_q;
      end
      if (ld1) relu1_q <= i_relu_en;
    end
  end

  assign m_valid   = m_valid_q;
  assign o_sat_cnt = cnt_q;
endmodule

// File: tb/tb_psum_requant.sv
// Directed bench for psum_requant: vector table plus back-pressure, counter and reset sequences.

module tb_psum_requant;
  logic        clk = 0;
  logic        reset_n = 0;
  logic [3:0]  i_shift = 0;
  logic        i_relu_en = 0;
  logic        i_clr_cnt = 0;
  logic        s_valid = 0;
  logic        s_ready;
  logic [83:0] s_psum = '0;
  logic        m_valid;
  logic        m_ready = 1;
  logic [63:0] m_psum;
  logic [3:0]  o_sat_cnt;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  psum_requant #(.LANES(4), .I_SUM_BW(21), .O_SUM_BW(16), .SHIFT_BW(4), .CNT_BW(4)) dut (
    .clk(clk), .reset_n(reset_n), .i_shift(i_shift), .i_relu_en(i_relu_en),
    .i_clr_cnt(i_clr_cnt), .s_valid(s_valid), .s_ready(s_ready), .s_psum(s_psum),
    .m_valid(m_valid), .m_ready(m_ready), .m_psum(m_psum), .o_sat_cnt(o_sat_cnt)
  );

  typedef struct {
    logic [3:0]  sh;
    logic        relu;
    logic [83:0] xin;
    logic [63:0] yout;
    int          cnt;
  } vec_t;

  function automatic logic [83:0] pack_i(int a, int b, int c, int d);
    return {21'(d), 21'(c), 21'(b), 21'(a)};
  endfunction

  function automatic logic [63:0] pack_o(int a, int b, int c, int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  vec_t vt[6];
  logic [15:0] pat = 16'b1011_0010_1101_0110;

  initial begin
    int sent, rx;
    logic stalled, acc;
    logic [63:0] hold;

    vt[0] = '{4'd1,  1'b0, pack_i(5, -5, 4, -1),                     pack_o(3, -2, 2, 0),                 0};
    vt[1] = '{4'd0,  1'b0, pack_i(1000000, -1048576, 32767, -32768), pack_o(32767, -32768, 32767, -32768), 2};
    vt[2] = '{4'd2,  1'b1, pack_i(-100, 100, -2, 200000),            pack_o(0, 25, 0, 32767),             3};
    vt[3] = '{4'd15, 1'b0, pack_i(-1048576, 1048575, 7, -16385),     pack_o(-32, 32, 0, -1),              3};
    vt[4] = '{4'd3,  1'b0, pack_i(-12, 12, -20, 20),                 pack_o(-1, 2, -2, 3),                3};
    vt[5] = '{4'd1,  1'b0, pack_i(65535, 65533, -65536, -65537),     pack_o(32767, 32767, -32768, -32768), 4};

    repeat (2) @(negedge clk);
    chk("rst_mvalid", m_valid, 0);
    chk("rst_mpsum", m_psum, 0);
    chk("rst_cnt", o_sat_cnt, 0);
    reset_n = 1;
    @(negedge clk);
    chk("rst_sready", s_ready, 1);

    // Table vectors: two edges from presentation to output, no back-pressure.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      i_shift = vt[i].sh; i_relu_en = vt[i].relu; s_psum = vt[i].xin; s_valid = 1;
      @(posedge clk);
      #1 s_valid = 0; i_relu_en = 0; i_shift = 0;
      @(negedge clk);
      chk($sformatf("v%0d_lat", i), m_valid, 0);
      @(negedge clk);
      chk($sformatf("v%0d_valid", i), m_valid, 1);
      chk($sformatf("v%0d_psum", i), m_psum, vt[i].yout);
      chk($sformatf("v%0d_cnt", i), o_sat_cnt, vt[i].cnt);
    end

    @(negedge clk) i_clr_cnt = 1;
    @(negedge clk) i_clr_cnt = 0;
    chk("clr_cnt", o_sat_cnt, 0);

    // Back-pressure stream of 8 beats.
    sent = 0; rx = 0; stalled = 0; hold = '0;
    for (int c = 0; c < 200 && rx < 8; c++) begin
      @(negedge clk);
      m_ready = pat[c % 16];
      i_shift = 0; i_relu_en = 0;
      if (sent < 8) begin
        s_valid = 1;
        s_psum  = pack_i(sent*10, sent*10+1, -(sent*10+2), sent*10+3);
      end else s_valid = 0;
      #1;
      if (stalled) begin
        chk("bp_hold_psum", m_psum, hold);
        chk("bp_hold_valid", m_valid, 1);
      end
      chk("bp_sready", s_ready, !(m_valid && !m_ready));
      if (m_valid && m_ready) begin
        chk($sformatf("bp_order%0d", rx), m_psum, pack_o(rx*10, rx*10+1, -(rx*10+2), rx*10+3));
        rx++;
      end
      stalled = m_valid && !m_ready;
      hold    = m_psum;
      acc     = s_valid && s_ready;
      @(posedge clk);
      if (acc) sent++;
    end
    chk("bp_count", rx, 8);
    @(negedge clk) s_valid = 0; m_ready = 1;
    chk("bp_cnt", o_sat_cnt, 0);

    // Counter clamps at 15 after 5 beats of 4 clipped lanes.
    @(negedge clk);
    s_psum = pack_i(1000000, 1000000, -1000000, -1000000); s_valid = 1;
    repeat (5) @(posedge clk);
    #1 s_valid = 0;
    repeat (3) @(negedge clk);
    chk("cnt_sat", o_sat_cnt, 15);

    // Clear on the same edge that a clipping beat loads stage 2.
    @(negedge clk) s_valid = 1;
    @(posedge clk);
    #1 s_valid = 0; i_clr_cnt = 1;
    @(posedge clk);
    #1 i_clr_cnt = 0;
    @(negedge clk);
    chk("clr_pri_valid", m_valid, 1);
    chk("clr_pri_cnt", o_sat_cnt, 0);

    // Reset with two beats in flight.
    @(negedge clk);
    m_ready = 0; s_valid = 1;
    @(posedge clk);
    @(negedge clk) s_psum = pack_i(7, 7, 7, 7);
    @(posedge clk);
    #1 s_valid = 0;
    @(negedge clk);
    chk("pre_rst_valid", m_valid, 1);
    chk("pre_rst_cnt", o_sat_cnt, 4);
    reset_n = 0;
    #1;
    chk("mid_rst_valid", m_valid, 0);
    chk("mid_rst_psum", m_psum, 0);
    chk("mid_rst_cnt", o_sat_cnt, 0);
    @(negedge clk) reset_n = 1; m_ready = 1;
    @(negedge clk);
    s_psum = pack_i(1, 2, 3, 4); s_valid = 1;
    @(posedge clk);
    #1 s_valid = 0;
    @(negedge clk);
    chk("post_rst_lat", m_valid, 0);
    @(negedge clk);
    chk("post_rst_valid", m_valid, 1);
    chk("post_rst_psum", m_psum, pack_o(1, 2, 3, 4));

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
